// File: rtl/shared_pkg.sv
// Shared types and default sizes for the FIFO access controller, its buffer and the bench.
package shared_pkg;

    typedef enum logic {
        SEL_P0 = 1'b0,
        SEL_P1 = 1'b1
    } arb_sel_e;

    localparam int unsigned NUM_REQ        = 2;
    localparam int unsigned FIFO_WIDTH_DEF = 16;
    localparam int unsigned FIFO_DEPTH_DEF = 8;

endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry in-order output buffer; entry 0 is always the head.
module fifo_out_skid
    import shared_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] ent0;
    logic [WIDTH-1:0] ent1;

    // Push lands behind whatever survives the pop in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 2'd0;
            ent0  <= '0;
            ent1  <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) ent0 <= push_data;
                    else               ent1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    ent0  <= ent1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        ent0 <= push_data;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_data = ent0;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && count == 2'd2));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && count == 2'd0));

endmodule

// File: rtl/fifo_access_ctrl.sv
// Shares one synchronous FIFO between two round-robin writers and drains it to a
// valid/ready consumer, absorbing the FIFO read latency; flags protocol errors.
module fifo_access_ctrl
    import shared_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req,
    input  logic [FIFO_WIDTH-1:0] p0_data,
    output logic                  p0_gnt,
    input  logic                  p1_req,
    input  logic [FIFO_WIDTH-1:0] p1_data,
    output logic                  p1_gnt,
    output logic                  fifo_wr_en,
    output logic [FIFO_WIDTH-1:0] fifo_data_in,
    input  logic                  fifo_full,
    input  logic                  fifo_wr_ack,
    input  logic                  fifo_overflow,
    output logic                  fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  err_wr,
    output logic                  err_rd
);

    arb_sel_e   rr_last;
    logic       wr_pending;
    logic       inflight;
    logic       pop;
    logic [1:0] buf_count;
    logic [2:0] occ;

    // Zero-latency round-robin grant; the requester that did not win last goes first on a tie.
    always_comb begin
        p0_gnt       = 1'b0;
        p1_gnt       = 1'b0;
        fifo_data_in = '0;
        if (rst_n && !fifo_full) begin
            if (p0_req && (!p1_req || rr_last == SEL_P1)) begin
                p0_gnt       = 1'b1;
                fifo_data_in = p0_data;
            end else if (p1_req) begin
                p1_gnt       = 1'b1;
                fifo_data_in = p1_data;
            end
        end
    end

    assign fifo_wr_en = p0_gnt | p1_gnt;

    // Read only while buffer plus in-flight word, after this cycle's pop, leaves a free slot.
    assign pop        = m_valid & m_ready;
    assign occ        = 3'(buf_count) + 3'(inflight) - 3'(pop);
    assign fifo_rd_en = rst_n & ~fifo_empty & (occ < 3'd2);
    assign m_valid    = (buf_count != 2'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_last    <= SEL_P1;
            wr_pending <= 1'b0;
            inflight   <= 1'b0;
            err_wr     <= 1'b0;
            err_rd     <= 1'b0;
        end else begin
            if (p0_gnt)      rr_last <= SEL_P0;
            else if (p1_gnt) rr_last <= SEL_P1;
            wr_pending <= fifo_wr_en;
            inflight   <= fifo_rd_en;
            if ((wr_pending && !fifo_wr_ack) || fifo_overflow) err_wr <= 1'b1;
            if (fifo_underflow || (fifo_rd_en && fifo_empty))  err_rd <= 1'b1;
        end
    end

    fifo_out_skid #(
        .WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (fifo_data_out),
        .pop       (pop),
        .head_data (m_data),
        .count     (buf_count)
    );

    a_depth: assert property (@(posedge clk) FIFO_DEPTH >= 2);

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Scoreboard bench: a queue-based FIFO environment, a rule-level arbitration model and an
// output monitor that checks every delivered word against the write order.
module tb_fifo_access_ctrl;
    import shared_pkg::*;

    localparam int unsigned W     = FIFO_WIDTH_DEF;
    localparam int unsigned DEPTH = FIFO_DEPTH_DEF;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         p0_req, p1_req, p0_gnt, p1_gnt;
    logic [W-1:0] p0_data, p1_data;
    logic         fifo_wr_en, fifo_full, fifo_wr_ack, fifo_overflow;
    logic [W-1:0] fifo_data_in, fifo_data_out, m_data;
    logic         fifo_rd_en, fifo_empty, fifo_underflow;
    logic         m_valid, m_ready, err_wr, err_rd;

    always #5 clk = ~clk;

    fifo_access_ctrl #(.FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_data(p0_data), .p0_gnt(p0_gnt),
        .p1_req(p1_req), .p1_data(p1_data), .p1_gnt(p1_gnt),
        .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in), .fifo_full(fifo_full),
        .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow),
        .fifo_rd_en(fifo_rd_en), .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
        .fifo_underflow(fifo_underflow),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .err_wr(err_wr), .err_rd(err_rd)
    );

    typedef struct {
        string       nm;
        logic [31:0] act;
        logic [31:0] exp;
    } dchk_t;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    dchk_t        dq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // FIFO environment: behavioural queue with one-cycle read data and registered ack.
    logic [W-1:0] fq[$];
    int           fq_n = 0;
    int           env_n;
    int           rd_total = 0;
    logic         env_ack = 1'b0, env_uf = 1'b0;
    logic [W-1:0] env_dout = '0;
    bit           preload_go = 0, force_full = 0, drop_ack = 0, force_uflow = 0;

    assign fifo_full      = force_full || (fq_n >= int'(DEPTH));
    assign fifo_empty     = (fq_n == 0);
    assign fifo_wr_ack    = env_ack & ~drop_ack;
    assign fifo_overflow  = 1'b0;
    assign fifo_underflow = env_uf | force_uflow;
    assign fifo_data_out  = env_dout;

    always @(posedge clk) begin
        env_n = fq.size();
        env_ack <= 1'b0;
        env_uf  <= 1'b0;
        if (fifo_rd_en) begin
            if (env_n > 0) begin
                env_dout <= fq.pop_front();
                rd_total++;
            end else begin
                env_uf <= 1'b1;
            end
        end
        if (fifo_wr_en && env_n < int'(DEPTH)) begin
            fq.push_back(fifo_data_in);
            env_ack <= 1'b1;
        end
        if (preload_go)
            for (int i = 0; i < 8; i++) fq.push_back(W'(32'h00A0 + i));
        fq_n <= fq.size();
    end

    // Arbitration reference: tie goes to whoever did not win last; winner's word is expected out.
    int           last_won = 1;
    int           w0 = 0, w1 = 0;
    bit           g0m = 0, g1m = 0;
    logic [W-1:0] din_m;

    always @(negedge clk) begin
        g0m = 0;
        g1m = 0;
        if (!rst_n) begin
            last_won = 1;
        end else if (!fifo_full) begin
            if (p0_req && p1_req) begin
                g0m = (last_won == 1);
                g1m = !g0m;
            end else begin
                g0m = p0_req;
                g1m = p1_req;
            end
        end
        din_m = g0m ? p0_data : (g1m ? p1_data : '0);
        chk("p0_gnt", 32'(p0_gnt), 32'(g0m));
        chk("p1_gnt", 32'(p1_gnt), 32'(g1m));
        chk("fifo_wr_en", 32'(fifo_wr_en), 32'(g0m | g1m));
        chk("fifo_data_in", 32'(fifo_data_in), 32'(din_m));
        if (g0m) begin exp_q.push_back(p0_data); last_won = 0; end
        if (g1m) begin exp_q.push_back(p1_data); last_won = 1; end
        if (rst_n && p0_req && !fifo_full) begin
            if (p0_gnt) w0 = 0;
            else begin w0++; chk("starve_p0", 32'(w0 <= 1), 32'd1); end
        end else if (!p0_req) w0 = 0;
        if (rst_n && p1_req && !fifo_full) begin
            if (p1_gnt) w1 = 0;
            else begin w1++; chk("starve_p1", 32'(w1 <= 1), 32'd1); end
        end else if (!p1_req) w1 = 0;
    end

    // Output monitor: pops the scoreboard on each accepted word, checks stall stability.
    bit           prev_stall = 0, prev_rst_low = 1, chk_err = 1;
    logic [W-1:0] prev_data = '0;
    int           delivered = 0;
    dchk_t        dd;

    always @(negedge clk) begin
        while (dq.size() > 0) begin
            dd = dq.pop_front();
            chk(dd.nm, dd.act, dd.exp);
        end
        if (!rst_n) begin
            chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
            if (prev_rst_low) begin
                chk("rst_m_valid", 32'(m_valid), 32'd0);
                chk("rst_err_wr", 32'(err_wr), 32'd0);
                chk("rst_err_rd", 32'(err_rd), 32'd0);
            end
            prev_stall   = 0;
            prev_rst_low = 1;
        end else begin
            prev_rst_low = 0;
            chk("held_le2", 32'((rd_total - delivered) <= 2), 32'd1);
            if (prev_stall) begin
                chk("stall_valid", 32'(m_valid), 32'd1);
                chk("stall_data", 32'(m_data), 32'(prev_data));
            end
            if (chk_err) begin
                chk("no_err_wr", 32'(err_wr), 32'd0);
                chk("no_err_rd", 32'(err_rd), 32'd0);
            end
            if (m_valid && m_ready) begin
                chk("sb_data", 32'(m_data), (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF);
                delivered++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input string nm, input logic [31:0] act, input logic [31:0] exp);
        dchk_t d;
        d.nm  = nm;
        d.act = act;
        d.exp = exp;
        dq.push_back(d);
    endtask

    task automatic preload();
        preload_go = 1;
        for (int i = 0; i < 8; i++) exp_q.push_back(W'(32'h00A0 + i));
        cyc();
        preload_go = 0;
    endtask

    initial begin
        int first_rd, first_v, first_del, last_del, ndel, nrd;
        rst_n = 0; m_ready = 0;
        p0_req = 1; p1_req = 1; p0_data = 16'h1111; p1_data = 16'h2222;

        // Reset with both requesters active and a non-empty FIFO.
        preload();
        repeat (2) cyc();
        #3;
        post("rst_fifo_empty", 32'(fifo_empty), 32'd0);
        post("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        post("rst_p0_gnt_d", 32'(p0_gnt), 32'd0);
        post("rst_m_valid_d", 32'(m_valid), 32'd0);

        // Read stream of the preloaded words.
        cyc();
        rst_n = 1; p0_req = 0; p1_req = 0; m_ready = 1;
        first_rd = -1; first_v = -1; first_del = -1; last_del = -1; ndel = 0;
        for (int k = 0; k < 16; k++) begin
            #3;
            if (fifo_rd_en && first_rd < 0) first_rd = k;
            if (m_valid && first_v < 0) first_v = k;
            if (m_valid && m_ready) begin
                if (first_del < 0) first_del = k;
                last_del = k;
                ndel++;
            end
            cyc();
        end
        post("rs_first_rd", 32'(first_rd), 32'd0);
        post("rs_latency", 32'(first_v - first_rd), 32'd2);
        post("rs_count", 32'(ndel), 32'd8);
        post("rs_span", 32'(last_del - first_del), 32'd7);

        // Consumer stall with a full buffer.
        m_ready = 0;
        preload();
        nrd = 0;
        for (int k = 0; k < 8; k++) begin
            #3;
            if (fifo_rd_en) nrd++;
            cyc();
        end
        #3;
        post("stall_rd_cnt", 32'(nrd), 32'd2);
        post("stall_m_valid", 32'(m_valid), 32'd1);
        post("stall_head", 32'(m_data), 32'h00A0);
        cyc();
        m_ready = 1;
        repeat (14) cyc();
        #3;
        post("stall_drained", 32'(exp_q.size()), 32'd0);

        // Round-robin between two continuous requesters.
        cyc();
        p0_req = 1; p1_req = 1; p0_data = 16'h1111; p1_data = 16'h2222;
        for (int k = 0; k < 4; k++) begin
            #3;
            post("rr_p0", 32'(p0_gnt), 32'(k % 2 == 0));
            post("rr_p1", 32'(p1_gnt), 32'(k % 2 == 1));
            post("rr_din", 32'(fifo_data_in), (k % 2 == 0) ? 32'h1111 : 32'h2222);
            cyc();
        end
        p0_req = 0; p1_req = 0;

        // Full backpressure on requester 1.
        cyc();
        p1_req = 1; p1_data = 16'h3333; force_full = 1;
        for (int k = 0; k < 3; k++) begin
            #3;
            post("full_p1_gnt", 32'(p1_gnt), 32'd0);
            post("full_wr_en", 32'(fifo_wr_en), 32'd0);
            cyc();
        end
        force_full = 0;
        #3;
        post("full_release", 32'(p1_gnt), 32'd1);
        cyc();
        p1_req = 0;

        // Randomised traffic; requests held until granted.
        for (int i = 0; i < 400; i++) begin
            bit new_ok;
            new_ok = (i < 390);
            if (g0m || !p0_req) begin
                p0_req  = new_ok && ($urandom_range(0, 2) != 0);
                p0_data = W'($urandom);
            end
            if (g1m || !p1_req) begin
                p1_req  = new_ok && ($urandom_range(0, 2) != 0);
                p1_data = W'($urandom);
            end
            m_ready    = !new_ok || ($urandom_range(0, 3) != 0);
            force_full = new_ok && ($urandom_range(0, 9) == 0);
            cyc();
        end
        p0_req = 0; p1_req = 0; force_full = 0; m_ready = 1;
        repeat (30) cyc();
        #3;
        post("rnd_drained", 32'(exp_q.size()), 32'd0);

        // Sticky error flags.
        cyc();
        chk_err = 0; drop_ack = 1; p0_req = 1; p0_data = 16'h5555;
        cyc();
        p0_req = 0;
        repeat (3) cyc();
        drop_ack = 0;
        #3;
        post("err_wr_set", 32'(err_wr), 32'd1);
        post("err_rd_clean", 32'(err_rd), 32'd0);
        repeat (3) cyc();
        #3;
        post("err_wr_sticky", 32'(err_wr), 32'd1);
        cyc();
        force_uflow = 1;
        cyc();
        force_uflow = 0;
        cyc();
        #3;
        post("err_rd_set", 32'(err_rd), 32'd1);
        post("err_wr_hold", 32'(err_wr), 32'd1);
        repeat (10) cyc();
        #3;
        post("err_rd_sticky", 32'(err_rd), 32'd1);
        post("err_drained", 32'(exp_q.size()), 32'd0);
        cyc();
        rst_n = 0;
        repeat (2) cyc();
        #3;
        post("clr_err_wr", 32'(err_wr), 32'd0);
        post("clr_err_rd", 32'(err_rd), 32'd0);
        cyc();
        rst_n = 1; chk_err = 1;
        repeat (3) cyc();
        #3;
        post("post_rst_err_wr", 32'(err_wr), 32'd0);
        post("post_rst_err_rd", 32'(err_rd), 32'd0);
        repeat (2) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_access_ctrl.md
Name: fifo_access_ctrl

Overview:
- Controller that shares one synchronous FIFO between two write requesters and drains it to a single valid/ready consumer.
- Write side: round-robin arbitration onto the FIFO write port, gated by full.
- Read side: issues rd_en and absorbs the FIFO's one-cycle read latency in a 2-entry output buffer, so the consumer sees a clean valid/ready stream.
- Checks FIFO protocol responses (wr_ack, overflow, underflow) and records violations in sticky error flags.

Parameters:
- FIFO_WIDTH, 16, data width of requesters, FIFO and consumer.
- FIFO_DEPTH, 8, depth of the controlled FIFO; informational only, no logic depends on it.

Ports:
- clk  in  1  single clock
- rst_n  in  1  synchronous active-low reset
- p0_req  in  1  requester 0 write request; held until granted
- p0_data  in  FIFO_WIDTH  requester 0 write data; stable while p0_req is high
- p0_gnt  out  1  requester 0 granted; data accepted at this clock edge
- p1_req  in  1  requester 1 write request
- p1_data  in  FIFO_WIDTH  requester 1 write data
- p1_gnt  out  1  requester 1 granted
- fifo_wr_en  out  1  FIFO write enable
- fifo_data_in  out  FIFO_WIDTH  FIFO write data
- fifo_full  in  1  FIFO full flag
- fifo_wr_ack  in  1  FIFO write acknowledge; registered, one cycle after the write
- fifo_overflow  in  1  FIFO overflow flag
- fifo_rd_en  out  1  FIFO read enable
- fifo_data_out  in  FIFO_WIDTH  FIFO read data; valid one cycle after rd_en
- fifo_empty  in  1  FIFO empty flag
- fifo_underflow  in  1  FIFO underflow flag
- m_valid  out  1  consumer data valid
- m_data  out  FIFO_WIDTH  consumer data, head of output buffer
- m_ready  in  1  consumer ready
- err_wr  out  1  sticky write-protocol error
- err_rd  out  1  sticky read-protocol error

Behaviour:
- Reset (rst_n=0 at posedge):
  - rr_last=1, so p0 wins the first tie.
  - buffer empty; inflight=0; wr_pending=0.
  - err_wr=0, err_rd=0; m_valid=0.
  - While rst_n=0, p0_gnt, p1_gnt, fifo_wr_en and fifo_rd_en are forced 0 combinationally.
  - Mid-operation reset discards buffered and inflight data.
- Write arbitration (combinational grant, zero latency):
  - No grant when fifo_full=1.
  - Only one requester active: that requester is granted.
  - Both active: grant the one != rr_last.
  - fifo_wr_en = p0_gnt | p1_gnt.
  - fifo_data_in = data of the granted requester; otherwise 0.
  - On any grant, rr_last <= granted index at the clock edge.
  - Starvation bound: a continuously requesting port is granted within 2 non-full cycles.
- Write check:
  - wr_pending <= fifo_wr_en.
  - err_wr sets if wr_pending=1 and fifo_wr_ack=0.
  - err_wr sets if fifo_overflow=1 in any cycle.
- Read scheduling:
  - Definitions: pop = m_valid & m_ready; occ = buf_count + inflight - pop.
  - fifo_rd_en = !fifo_empty & (occ < 2).
  - inflight <= fifo_rd_en.
  - When inflight=1, fifo_data_out is pushed into the buffer tail at that edge.
  - Simultaneous push and pop in one cycle is legal; the count stays the same.
  - Sustained throughput is 1 word/cycle when m_ready is held high.
- Output buffer:
  - 2 entries, in-order.
  - m_valid = (buf_count != 0); m_data = head entry.
  - While m_valid=1 and m_ready=0, m_data holds stable.
  - The buffer never overflows, guaranteed by the occ rule; an overflowing push is an assertion failure.
- Read check:
  - err_rd sets if fifo_underflow=1.
  - err_rd sets if fifo_rd_en=1 while fifo_empty=1 (internal consistency check).
- Sticky errors clear only on reset.

Decomposition:
- shared_pkg: typedef enum logic {SEL_P0, SEL_P1} arb_sel_e; localparam NUM_REQ=2; FIFO_WIDTH/FIFO_DEPTH defaults shared with the FIFO and bench.
- Sub-module fifo_out_skid:
  - the 2-entry in-order buffer;
  - ports: clk, rst_n, push, push_data, pop, head_data, count[1:0].
- Arbitration and read scheduling stay in the top.

Test Plan:
- Reset: drive rst_n=0 with p0_req=p1_req=1 and fifo_empty=0 -> all grants, fifo_wr_en, fifo_rd_en, m_valid and err flags are 0.
- Round-robin: p0_req=p1_req=1 for 4 non-full cycles with p0_data=0x1111, p1_data=0x2222 -> grants alternate p0,p1,p0,p1; fifo_data_in alternates 0x1111,0x2222.
- Full backpressure: fifo_full=1 with p1_req=1 for 3 cycles -> p1_gnt=0 and fifo_wr_en=0 throughout; first cycle after full drops -> p1_gnt=1.
- Read stream: FIFO preloaded with 0xA0..0xA7, m_ready=1 -> m_valid rises 2 cycles after the first fifo_rd_en; 8 words delivered in order on consecutive cycles.
- Consumer stall: m_ready=0 with the buffer filled -> at most 2 rd_en issued; m_data holds 0xA0 stable; m_ready=1 resumes with no loss or duplication.
- Error flags:
  - Issue a write with fifo_wr_ack held 0 next cycle -> err_wr=1 and it stays 1.
  - Pulse fifo_underflow -> err_rd=1; only rst_n=0 clears both.
